// File: rtl/fp_add_normalize_round_pkg.sv
// Shared widths, payload types and small helpers for the FP add/sub
// normalize-and-round stage.
package fp_pkg;

   localparam int unsigned EXP_W   = 8;
   localparam int unsigned MAN_W   = 23;
   localparam int unsigned MW      = MAN_W + 5;
   localparam int unsigned RES_W   = 1 + EXP_W + MAN_W;
   localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
   localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
   localparam int unsigned LZ_W    = $clog2(MW + 1);

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MW-1:0]    mant;
   } fp_raw_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   // 8-bit leading-zero count; a result of 8 marks an all-zero tile.
   function automatic logic [3:0] lzc8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd8;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) n = 4'(7 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/fp_add_normalize_round_if.sv
// Input beat and output result handshake bundle for the normalize/round stage.
interface fp_add_normalize_round_if;
   import fp_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic             in_sign;
   logic [EXP_W-1:0] in_exp;
   logic [MW-1:0]    in_mant;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_result;
   logic             out_overflow;
   logic             out_underflow;
   logic             out_inexact;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
   );

endinterface

// File: rtl/fp_add_normalize_round_lzc.sv
// Leading-zero counter over the MW-bit mantissa, assembled from 8-bit tiles.
module lzc_mw
   import fp_pkg::*;
(
   input  logic [MW-1:0]   i_data,
   output logic [LZ_W-1:0] o_lz,
   output logic            o_zero
);

   localparam int unsigned NT  = (MW + 7) / 8;
   localparam int unsigned PAD = NT * 8 - MW;

   logic [NT*8-1:0] w_pad;
   logic [3:0]      w_tile [NT];

   // Ones below the data cap the padded count at exactly MW for a zero input.
   assign w_pad  = {i_data, {PAD{1'b1}}};
   assign o_zero = (i_data == '0);

   for (genvar t = 0; t < NT; t++) begin : g_tile
      assign w_tile[t] = lzc8(w_pad[(NT - t) * 8 - 1 -: 8]);
   end

   // Most significant non-empty tile wins; scanned low-to-high so it lands last.
   always_comb begin
      o_lz = '0;
      for (int t = int'(NT) - 1; t >= 0; t--) begin
         if (!w_tile[t][3]) o_lz = LZ_W'(t * 8) + LZ_W'(w_tile[t][2:0]);
      end
   end

endmodule

// File: rtl/fp_add_normalize_round.sv
// Two-stage post-adder pipeline: normalize (LZC + shift + denormal clamp),
// then round-to-nearest-even with overflow handling into a packed result.
module fp_add_normalize_round
   import fp_pkg::*;
(
   input logic                     clk,
   input logic                     rst_n,
   fp_add_normalize_round_if.slave bus
);

   logic                    w_adv;
   logic [LZ_W-1:0]         w_lz;
   logic                    w_zero;
   logic signed [EXP_W+1:0] w_sh;
   logic signed [EXP_W+1:0] w_diff;
   logic [LZ_W-1:0]         w_shamt;
   fp_raw_t                 w_s1_d;

   logic                    r_s1_valid;
   fp_raw_t                 r_s1;
   logic                    r_out_valid;
   logic [RES_W-1:0]        r_result;
   fp_flags_t               r_flags;

   logic                    w_g, w_r, w_s, w_lsb, w_rup;
   logic [MAN_W+1:0]        w_sum;
   logic [EXP_W:0]          w_exp_r;
   logic [MAN_W-1:0]        w_frac_r;
   logic [RES_W-1:0]        w_result;
   fp_flags_t               w_flags;
   logic                    w_unused;

   assign w_adv    = ~r_out_valid | bus.out_ready;
   assign w_unused = r_s1.mant[MW-1];

   lzc_mw u_lzc (
      .i_data (bus.in_mant),
      .o_lz   (w_lz),
      .o_zero (w_zero)
   );

   // Stage 1: bring the leading one to the hidden position, clamped at exp 0.
   always_comb begin
      w_s1_d  = '0;
      w_shamt = '0;
      w_sh    = $signed((EXP_W + 2)'(w_lz) - (EXP_W + 2)'(1));
      w_diff  = $signed((EXP_W + 2)'(bus.in_exp)) - w_sh;
      if (w_zero) begin
         w_s1_d = '0;
      end else if (bus.in_mant[MW-1]) begin
         w_s1_d.sign = bus.in_sign;
         w_s1_d.exp  = bus.in_exp + EXP_W'(1);
         w_s1_d.mant = {1'b0, bus.in_mant[MW-1:2], bus.in_mant[1] | bus.in_mant[0]};
      end else begin
         w_s1_d.sign = bus.in_sign;
         if (w_diff > $signed((EXP_W + 2)'(0))) begin
            w_shamt    = LZ_W'(w_sh);
            w_s1_d.exp = EXP_W'(w_diff);
         end else begin
            w_shamt    = (bus.in_exp != '0) ? LZ_W'(bus.in_exp - EXP_W'(1)) : '0;
            w_s1_d.exp = '0;
         end
         w_s1_d.mant = bus.in_mant << w_shamt;
      end
   end

   // Stage 2: RNE increment, renormalize on carry-out, saturate to infinity.
   always_comb begin
      w_g      = r_s1.mant[2];
      w_r      = r_s1.mant[1];
      w_s      = r_s1.mant[0];
      w_lsb    = r_s1.mant[3];
      w_rup    = w_g & (w_r | w_s | w_lsb);
      w_sum    = {1'b0, r_s1.mant[MW-2:3]} + (MAN_W + 2)'(w_rup);
      w_exp_r  = {1'b0, r_s1.exp};
      w_frac_r = w_sum[MAN_W-1:0];
      if (w_sum[MAN_W+1]) begin
         w_exp_r  = w_exp_r + (EXP_W + 1)'(1);
         w_frac_r = '0;
      end else if ((r_s1.exp == '0) && w_sum[MAN_W]) begin
         w_exp_r = (EXP_W + 1)'(1);
      end
      w_flags  = '0;
      w_result = {r_s1.sign, w_exp_r[EXP_W-1:0], w_frac_r};
      if (w_exp_r >= (EXP_W + 1)'(EXP_MAX)) begin
         w_flags.overflow = 1'b1;
         w_result         = {r_s1.sign, EXP_W'(EXP_MAX), MAN_W'(0)};
      end
      w_flags.inexact   = w_g | w_r | w_s | w_flags.overflow;
      w_flags.underflow = (w_exp_r == '0) & w_flags.inexact;
   end

   // Both stages advance together, bubbles included, whenever the output is free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1        <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
      end else if (w_adv) begin
         r_s1_valid  <= bus.in_valid;
         r_s1        <= w_s1_d;
         r_out_valid <= r_s1_valid;
         r_result    <= w_result;
         r_flags     <= w_flags;
      end
   end

   assign bus.in_ready      = w_adv;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_result    = r_result;
   assign bus.out_overflow  = r_flags.overflow;
   assign bus.out_underflow = r_flags.underflow;
   assign bus.out_inexact   = r_flags.inexact;

endmodule

// File: tb/tb_fp_add_normalize_round.sv
// Directed + randomized bench for fp_add_normalize_round with an exact-arithmetic
// rounding model and an in-order scoreboard.
module tb_fp_add_normalize_round;
   import fp_pkg::*;

   typedef struct packed {
      logic [RES_W-1:0] res;
      logic [2:0]       flg;
   } exp_t;

   localparam int HID = int'(MAN_W) + 3;

   logic clk;
   logic rst_n;
   fp_add_normalize_round_if bus ();

   fp_add_normalize_round dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int               n_checks = 0;
   int               n_fail   = 0;
   exp_t             q[$];
   exp_t             cur;
   logic             acc;
   logic             smp_ov;
   logic             smp_ir;
   logic [RES_W-1:0] smp_res;

   // Reference: exact value M * 2^(e - HID), rounded to nearest-even on the IEEE grid.
   function automatic exp_t model(input logic s, input logic [EXP_W-1:0] e, input logic [MW-1:0] m);
      exp_t        r;
      int          p, ee, k;
      logic [63:0] sig, rem, half;
      logic        inx;
      r = '0;
      if (m == '0) return r;
      p = 0;
      for (int i = 0; i < int'(MW); i++) if (m[i]) p = i;
      ee = int'(e) + p - HID;
      if (ee >= 1) k = p - int'(MAN_W);
      else begin
         ee = 0;
         k  = HID - int'(MAN_W) + 1 - int'(e);
      end
      if (k > 0) begin
         sig  = 64'(m) >> k;
         rem  = 64'(m) & ((64'd1 << k) - 64'd1);
         half = 64'd1 << (k - 1);
      end else begin
         sig  = 64'(m) << (-k);
         rem  = 64'd0;
         half = 64'd1;
      end
      inx = (rem != 64'd0);
      if ((rem > half) || ((rem == half) && sig[0])) sig = sig + 64'd1;
      if (sig == (64'd1 << (MAN_W + 1))) begin
         sig = 64'd1 << MAN_W;
         ee  = ee + 1;
      end
      if ((ee == 0) && (sig >= (64'd1 << MAN_W))) ee = 1;
      if (ee >= int'(EXP_MAX)) begin
         r.res = {s, EXP_W'(EXP_MAX), MAN_W'(0)};
         r.flg = 3'b101;
      end else begin
         r.res = {s, EXP_W'(ee), sig[MAN_W-1:0]};
         r.flg = {1'b0, (ee == 0) && inx, inx};
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // One clock: sample at negedge, score transfers, then return just after posedge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      smp_ov  = bus.out_valid;
      smp_ir  = bus.in_ready;
      smp_res = bus.out_result;
      acc     = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
         chk("output_expected", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("result", 64'(bus.out_result), 64'(e.res));
            chk("flags", 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact}), 64'(e.flg));
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         q.push_back(cur);
         acc = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic s, input logic [EXP_W-1:0] e, input logic [MW-1:0] m);
      bus.in_valid = 1'b1;
      bus.in_sign  = s;
      bus.in_exp   = e;
      bus.in_mant  = m;
   endtask

   task automatic send(input logic s, input logic [EXP_W-1:0] e, input logic [MW-1:0] m,
                       input logic [RES_W-1:0] r, input logic [2:0] f);
      set_in(s, e, m);
      cur.res = r;
      cur.flg = f;
      acc     = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) step();
      chk("send_accepted", 64'(acc), 64'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic rand_in();
      logic             s;
      logic [EXP_W-1:0] e;
      logic [MW-1:0]    m;
      s = 1'($urandom());
      e = EXP_W'($urandom_range(1, EXP_MAX - 1));
      m = MW'($urandom()) >> $urandom_range(0, MW - 1);
      if ($urandom_range(0, 19) == 0) m = '0;
      set_in(s, e, m);
      cur = model(s, e, m);
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = '0;
      bus.in_mant   = '0;
      bus.out_ready = 1'b0;
      cur           = '0;
      step();
      step();
      chk("reset_out_valid", 64'(smp_ov), 64'd0);
      chk("reset_result", 64'(smp_res), 64'd0);
      chk("reset_flags", 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact}), 64'd0);
      chk("reset_in_ready", 64'(smp_ir), 64'd1);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;

      // Carry case, then check the two-cycle latency on an otherwise idle pipe.
      send(1'b0, EXP_W'(BIAS), 28'h8000000, 32'h40000000, 3'b000);
      step();
      chk("latency_not_early", 64'(smp_ov), 64'd0);
      step();
      chk("latency_two", 64'(smp_ov), 64'd1);

      send(1'b0, 8'h7F, 28'h0000008, 32'h34000000, 3'b000);
      send(1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 3'b001);
      send(1'b0, 8'h7F, 28'h400000C, 32'h3F800002, 3'b001);
      send(1'b0, 8'hFE, 28'h7FFFFFC, 32'h7F800000, 3'b101);
      send(1'b0, 8'h01, 28'h2000000, 32'h00400000, 3'b000);
      send(1'b1, 8'h55, 28'h0000000, 32'h00000000, 3'b000);
      drain();

      // Backpressure: two beats fill the pipe, the third must wait.
      bus.out_ready = 1'b0;
      set_in(1'b0, 8'h7F, 28'h4000004); cur = model(1'b0, 8'h7F, 28'h4000004);
      step();
      chk("bp_accept_a", 64'(acc), 64'd1);
      set_in(1'b1, 8'h80, 28'h400000C); cur = model(1'b1, 8'h80, 28'h400000C);
      step();
      chk("bp_accept_b", 64'(acc), 64'd1);
      set_in(1'b0, 8'hFE, 28'h7FFFFFC); cur = model(1'b0, 8'hFE, 28'h7FFFFFC);
      step();
      chk("bp_in_ready_low", 64'(smp_ir), 64'd0);
      chk("bp_hold_c", 64'(acc), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_stalled_valid", 64'(smp_ov), 64'd1);
         chk("bp_stable_result", 64'(smp_res), 64'(q[0].res));
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp_accept_c", 64'(acc), 64'd1);
      chk("bp_out_1", 64'(smp_ov), 64'd1);
      bus.in_valid = 1'b0;
      step();
      chk("bp_out_2", 64'(smp_ov), 64'd1);
      step();
      chk("bp_out_3", 64'(smp_ov), 64'd1);
      step();
      chk("bp_done", 64'(smp_ov), 64'd0);
      chk("bp_queue_empty", 64'(q.size()), 64'd0);

      // Randomized traffic with random consumer stalls.
      bus.in_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!bus.in_valid && ($urandom_range(0, 3) != 0)) rand_in();
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
         if (acc) bus.in_valid = 1'b0;
      end
      drain();

      // Reset in the middle of a stream discards everything in flight.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_in();
         step();
      end
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      step();
      q.delete();
      rst_n = 1'b1;
      step();
      chk("rst_mid_out_valid", 64'(smp_ov), 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rst_no_stale", 64'(smp_ov), 64'd0);
      end
      send(1'b0, 8'h7F, 28'h8000000, 32'h40000000, 3'b000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
